// File: rtl/slc3_fetch_pkg.sv
// rtl/slc3_fetch_pkg.sv - shared types and PC-select codes for the SLC-3 fetch path
package slc3_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    LOAD_IR = 2'd2
  } fetch_state_t;

  // PC select codes used by the control FSM; pc_inc requests PCMUX_INC.
  localparam logic [1:0] PCMUX_INC  = 2'b00;
  localparam logic [1:0] PCMUX_ADDR = 2'b01;
  localparam logic [1:0] PCMUX_BUS  = 2'b10;

endpackage

// File: rtl/fetch_wait_counter.sv
// rtl/fetch_wait_counter.sv - saturating count of ready-less READ cycles
module fetch_wait_counter #(
  parameter int MAX_WAIT = 15
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(MAX_WAIT);
  localparam logic [CW-1:0] LAST  = CW'(MAX_WAIT - 1);

  logic [CW-1:0] count_q, count_d;

  // expired marks the edge on which the count reaches MAX_WAIT.
  assign expired = enable && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != LIMIT)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - SLC-3 instruction fetch: MAR, PC+1, memory read, IR load
module fetch_sequencer
  import slc3_fetch_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter int                MAX_WAIT = 15,
  parameter logic [DATA_W-1:0] IR_RESET = '0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] mar,
  output logic              mem_rd,
  output logic [DATA_W-1:0] mdr,
  output logic [DATA_W-1:0] ir,
  output logic              pc_inc,
  output logic              ir_valid,
  output logic              busy,
  output logic              fetch_err
);

  fetch_state_t      state_q, state_d;
  logic [DATA_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              pc_inc_q, pc_inc_d;
  logic              ir_valid_q, ir_valid_d;
  logic              fetch_err_q, fetch_err_d;
  logic              wait_clear;
  logic              wait_enable;
  logic              wait_expired;

  assign wait_enable = (state_q == READ) && !mem_ready;

  fetch_wait_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait (
    .Clk     (Clk),
    .Reset   (Reset),
    .clear   (wait_clear),
    .enable  (wait_enable),
    .expired (wait_expired)
  );

  always_comb begin
    state_d     = state_q;
    mar_d       = mar_q;
    mdr_d       = mdr_q;
    ir_d        = ir_q;
    pc_inc_d    = 1'b0;
    ir_valid_d  = 1'b0;
    fetch_err_d = fetch_err_q;
    wait_clear  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          mar_d       = pc_in;
          pc_inc_d    = 1'b1;
          fetch_err_d = 1'b0;
          wait_clear  = 1'b1;
          state_d     = READ;
        end
      end
      READ: begin
        // abort wins over both a completing read and a timeout
        if (abort) begin
          state_d = IDLE;
        end else if (mem_ready) begin
          mdr_d   = mem_rdata;
          state_d = LOAD_IR;
        end else if (wait_expired) begin
          fetch_err_d = 1'b1;
          state_d     = IDLE;
        end
      end
      LOAD_IR: begin
        if (!abort) begin
          ir_d       = mdr_q;
          ir_valid_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      mar_q       <= '0;
      mdr_q       <= '0;
      ir_q        <= IR_RESET;
      pc_inc_q    <= 1'b0;
      ir_valid_q  <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mar_q       <= mar_d;
      mdr_q       <= mdr_d;
      ir_q        <= ir_d;
      pc_inc_q    <= pc_inc_d;
      ir_valid_q  <= ir_valid_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  assign mem_rd    = (state_q == READ);
  assign busy      = (state_q != IDLE);
  assign mar       = mar_q;
  assign mdr       = mdr_q;
  assign ir        = ir_q;
  assign pc_inc    = pc_inc_q;
  assign ir_valid  = ir_valid_q;
  assign fetch_err = fetch_err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - scoreboard bench for fetch_sequencer
module tb_fetch_sequencer;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        start;
  logic        abort;
  logic [15:0] pc_in;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic [15:0] mar;
  logic        mem_rd;
  logic [15:0] mdr;
  logic [15:0] ir;
  logic        pc_inc;
  logic        ir_valid;
  logic        busy;
  logic        fetch_err;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int pcinc_cnt = 0;
  logic [15:0] exp_q[$];

  fetch_sequencer #(
    .DATA_W   (16),
    .MAX_WAIT (15),
    .IR_RESET (16'h0000)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .start     (start),
    .abort     (abort),
    .pc_in     (pc_in),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .mar       (mar),
    .mem_rd    (mem_rd),
    .mdr       (mdr),
    .ir        (ir),
    .pc_inc    (pc_inc),
    .ir_valid  (ir_valid),
    .busy      (busy),
    .fetch_err (fetch_err)
  );

  always #5 Clk = ~Clk;

  // Pops the expected instruction whenever the DUT announces a new IR.
  always @(negedge Clk) begin
    if (!Reset && pc_inc) pcinc_cnt++;
    if (!Reset && ir_valid) begin
      valid_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_ir_valid ir=%h expected none", ir);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (ir !== e) begin
          errors++;
          $display("FAIL sb_ir got=%h exp=%h", ir, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic issue_start(input logic [15:0] pc);
    pc_in = pc;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; start = 1'b0; abort = 1'b0; pc_in = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    #12;
    checks++;
    if ({mar, mdr, ir} !== 48'h0) begin
      errors++; $display("FAIL reset_regs mar=%h mdr=%h ir=%h exp 0", mar, mdr, ir);
    end
    checks++;
    if ({mem_rd, busy, pc_inc, ir_valid, fetch_err} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got=%b exp=00000", {mem_rd, busy, pc_inc, ir_valid, fetch_err});
    end
    Reset = 1'b0;
    step();
  endtask

  task automatic test_zero_wait();
    int v0;
    v0 = valid_cnt;
    issue_start(16'h3000);
    checks++;
    if ({pc_inc, mem_rd, busy} !== 3'b111 || mar !== 16'h3000) begin
      errors++; $display("FAIL zw_e0 pc_inc/mem_rd/busy=%b mar=%h exp 111 3000", {pc_inc, mem_rd, busy}, mar);
    end
    mem_ready = 1'b1; mem_rdata = 16'h1234; exp_q.push_back(16'h1234);
    step();
    mem_ready = 1'b0;
    checks++;
    if (mdr !== 16'h1234 || pc_inc !== 1'b0 || mem_rd !== 1'b0) begin
      errors++; $display("FAIL zw_e1 mdr=%h pc_inc=%b mem_rd=%b exp 1234 0 0", mdr, pc_inc, mem_rd);
    end
    step();
    checks++;
    if (ir !== 16'h1234 || ir_valid !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL zw_e2 ir=%h ir_valid=%b busy=%b exp 1234 1 0", ir, ir_valid, busy);
    end
    step();
    checks++;
    if (ir_valid !== 1'b0 || valid_cnt != v0 + 1) begin
      errors++; $display("FAIL zw_pulse ir_valid=%b pulses=%0d exp 0 1", ir_valid, valid_cnt - v0);
    end
  endtask

  task automatic test_wait_states();
    int rd_cycles;
    rd_cycles = 0;
    issue_start(16'h3001);
    for (int i = 0; i < 4; i++) begin
      if (mem_rd) rd_cycles++;
      mem_ready = (i == 3);
      if (i == 3) begin
        mem_rdata = 16'hABCD;
        exp_q.push_back(16'hABCD);
      end
      step();
    end
    mem_ready = 1'b0;
    checks++;
    if (rd_cycles != 4 || mem_rd !== 1'b0) begin
      errors++; $display("FAIL ws_mem_rd cycles=%0d mem_rd=%b exp 4 0", rd_cycles, mem_rd);
    end
    step();
    checks++;
    if (ir !== 16'hABCD || fetch_err !== 1'b0) begin
      errors++; $display("FAIL ws_ir ir=%h fetch_err=%b exp abcd 0", ir, fetch_err);
    end
    step();
  endtask

  task automatic test_timeout();
    int n;
    int v0;
    v0 = valid_cnt;
    n = 0;
    issue_start(16'h3002);
    while (mem_rd && n < 40) begin
      n++;
      step();
    end
    checks++;
    if (n != 15) begin
      errors++; $display("FAIL to_cycles read_cycles=%0d exp 15", n);
    end
    checks++;
    if (fetch_err !== 1'b1 || busy !== 1'b0 || ir !== 16'hABCD || valid_cnt != v0) begin
      errors++; $display("FAIL to_state err=%b busy=%b ir=%h pulses=%0d exp 1 0 abcd 0", fetch_err, busy, ir, valid_cnt - v0);
    end
    step();
    checks++;
    if (fetch_err !== 1'b1) begin
      errors++; $display("FAIL to_sticky fetch_err=%b exp 1", fetch_err);
    end
    issue_start(16'h3003);
    checks++;
    if (fetch_err !== 1'b0) begin
      errors++; $display("FAIL to_clear fetch_err=%b exp 0", fetch_err);
    end
    mem_ready = 1'b1; mem_rdata = 16'h0F0F; exp_q.push_back(16'h0F0F);
    step();
    mem_ready = 1'b0;
    step();
    step();
  endtask

  task automatic test_ready_at_limit();
    issue_start(16'h3004);
    for (int i = 0; i < 14; i++) step();
    mem_ready = 1'b1; mem_rdata = 16'h7777; exp_q.push_back(16'h7777);
    step();
    mem_ready = 1'b0;
    checks++;
    if (fetch_err !== 1'b0 || mdr !== 16'h7777 || busy !== 1'b1) begin
      errors++; $display("FAIL limit_accept err=%b mdr=%h busy=%b exp 0 7777 1", fetch_err, mdr, busy);
    end
    step();
    step();
  endtask

  task automatic test_abort();
    int v0;
    v0 = valid_cnt;
    issue_start(16'h4000);
    abort = 1'b1; mem_ready = 1'b1; mem_rdata = 16'h5555;
    step();
    abort = 1'b0; mem_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || mdr !== 16'h7777 || ir !== 16'h7777 || ir_valid !== 1'b0) begin
      errors++; $display("FAIL abort_read busy=%b mdr=%h ir=%h ir_valid=%b exp 0 7777 7777 0", busy, mdr, ir, ir_valid);
    end
    issue_start(16'h4001);
    mem_ready = 1'b1; mem_rdata = 16'h6666;
    step();
    mem_ready = 1'b0; abort = 1'b1;
    step();
    abort = 1'b0;
    step();
    checks++;
    if (ir !== 16'h7777 || mdr !== 16'h6666 || valid_cnt != v0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_load ir=%h mdr=%h pulses=%0d busy=%b exp 7777 6666 0 0", ir, mdr, valid_cnt - v0, busy);
    end
  endtask

  task automatic test_back_to_back();
    int v0;
    int p0;
    v0 = valid_cnt;
    p0 = pcinc_cnt;
    issue_start(16'h5000);
    pc_in = 16'h5100; start = 1'b1;
    step();
    start = 1'b0; mem_ready = 1'b1; mem_rdata = 16'h1111; exp_q.push_back(16'h1111);
    step();
    mem_ready = 1'b0;
    step();
    checks++;
    if (mar !== 16'h5000 || ir_valid !== 1'b1) begin
      errors++; $display("FAIL busy_ignore mar=%h ir_valid=%b exp 5000 1", mar, ir_valid);
    end
    issue_start(16'h5001);
    mem_ready = 1'b1; mem_rdata = 16'h2222; exp_q.push_back(16'h2222);
    step();
    mem_ready = 1'b0;
    step();
    step();
    checks++;
    if (valid_cnt != v0 + 2 || pcinc_cnt != p0 + 2 || mar !== 16'h5001 || ir !== 16'h2222) begin
      errors++; $display("FAIL b2b pulses=%0d pc_incs=%0d mar=%h ir=%h exp 2 2 5001 2222", valid_cnt - v0, pcinc_cnt - p0, mar, ir);
    end
  endtask

  task automatic test_async_reset();
    issue_start(16'h6000);
    #2;
    Reset = 1'b1;
    #1;
    checks++;
    if (mem_rd !== 1'b0 || busy !== 1'b0 || ir !== 16'h0000 || mar !== 16'h0000) begin
      errors++; $display("FAIL async_reset mem_rd=%b busy=%b ir=%h mar=%h exp 0 0 0000 0000", mem_rd, busy, ir, mar);
    end
    #3;
    Reset = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || pc_inc !== 1'b0) begin
      errors++; $display("FAIL post_reset busy=%b pc_inc=%b exp 0 0", busy, pc_inc);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_timeout();
    test_ready_at_limit();
    test_abort();
    test_back_to_back();
    test_async_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL sb_leftover pending=%0d exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
